sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder.sv | 188 ++++++++++++++++++
 tb/tb_sample_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_feeder.sv
// Sample feeder: streams samples from a synchronous-read memory to a channel.
// It issues a feed-reset pulse first, then presents one sample per DIV-cycle period with a sample clock.
module sample_feeder #(
  parameter int INPUT_WIDTH  = 3,
  parameter int ADDR_WIDTH   = 14,
  parameter int DIV          = 4,
  parameter int RESET_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    num_samples,
  input  logic                   pause,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INPUT_WIDTH-1:0] mem_data,
  output logic                   clk_sample,
  output logic                   sample_valid,
  output logic [INPUT_WIDTH-1:0] data,
  output logic                   feed_reset,
  output logic                   feed_complete,
  output logic                   busy,
  output logic [ADDR_WIDTH:0]    samples_sent
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [PW-1:0]         PH_ZERO  = PW'(0);
  localparam logic [PW-1:0]         PH_HALF  = PW'(DIV / 2);
  localparam logic [PW-1:0]         PH_LAST  = PW'(DIV - 1);
  localparam logic [TW-1:0]         TM_ZERO  = TW'(0);
  localparam logic [TW-1:0]         TM_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH + 1)'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FEED_RESET = 3'd1;
  localparam logic [2:0] ST_PRIME      = 3'd2;
  localparam logic [2:0] ST_FEED       = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   clk_sample_q, clk_sample_d;
  logic                   feed_complete_q, feed_complete_d;
  logic                   feed_reset_q, feed_reset_d;
  logic                   busy_q, busy_d;
  logic [ADDR_WIDTH:0]    samples_sent_q, samples_sent_d;

  // Next-state and next-output logic for the feed sequencer.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    phase_d         = phase_q;
    count_d         = count_q;
    mem_addr_d      = mem_addr_q;
    data_d          = data_q;
    sample_valid_d  = sample_valid_q;
    clk_sample_d    = clk_sample_q;
    feed_complete_d = feed_complete_q;
    samples_sent_d  = samples_sent_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d         = ST_FEED_RESET;
          count_d         = num_samples;
          samples_sent_d  = CNT_ZERO;
          mem_addr_d      = {ADDR_WIDTH{1'b0}};
          feed_complete_d = 1'b0;
          timer_d         = TM_ZERO;
        end else begin
          state_d = state_q;
        end
      end

      ST_FEED_RESET: begin
        if (timer_q == TM_LAST) begin
          timer_d = TM_ZERO;
          if (count_q == CNT_ZERO) begin
            state_d         = ST_DONE;
            feed_complete_d = 1'b1;
          end else begin
            state_d = ST_PRIME;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // One cycle with address 0 presented so the first word is ready at phase 0.
      ST_PRIME: begin
        state_d    = ST_FEED;
        phase_d    = PH_ZERO;
        mem_addr_d = {ADDR_WIDTH{1'b0}};
      end

      ST_FEED: begin
        if (phase_q == PH_ZERO) begin
          clk_sample_d = 1'b0;
          if (pause) begin
            phase_d = PH_ZERO;
          end else begin
            data_d         = mem_data;
            sample_valid_d = 1'b1;
            mem_addr_d     = mem_addr_q + ADDR_ONE;
            phase_d        = phase_q + PW'(1);
          end
        end else if ((phase_q == PH_LAST) && (samples_sent_q == count_q)) begin
          state_d         = ST_DONE;
          clk_sample_d    = 1'b0;
          sample_valid_d  = 1'b0;
          feed_complete_d = 1'b1;
          phase_d         = PH_ZERO;
        end else begin
          if (phase_q == PH_HALF) begin
            clk_sample_d = 1'b1;
            if (samples_sent_q != count_q) begin
              samples_sent_d = samples_sent_q + (ADDR_WIDTH + 1)'(1);
            end else begin
              samples_sent_d = samples_sent_q;
            end
          end else begin
            clk_sample_d = clk_sample_q;
          end
          if (phase_q == PH_LAST) begin
            phase_d = PH_ZERO;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    feed_reset_d = (state_d == ST_FEED_RESET);
    busy_d       = (state_d == ST_FEED_RESET) || (state_d == ST_PRIME) || (state_d == ST_FEED);
  end

  // State and output registers; reset aborts any feed without flagging completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= TM_ZERO;
      phase_q         <= PH_ZERO;
      count_q         <= CNT_ZERO;
      mem_addr_q      <= {ADDR_WIDTH{1'b0}};
      data_q          <= {INPUT_WIDTH{1'b0}};
      sample_valid_q  <= 1'b0;
      clk_sample_q    <= 1'b0;
      feed_complete_q <= 1'b0;
      feed_reset_q    <= 1'b0;
      busy_q          <= 1'b0;
      samples_sent_q  <= CNT_ZERO;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      phase_q         <= phase_d;
      count_q         <= count_d;
      mem_addr_q      <= mem_addr_d;
      data_q          <= data_d;
      sample_valid_q  <= sample_valid_d;
      clk_sample_q    <= clk_sample_d;
      feed_complete_q <= feed_complete_d;
      feed_reset_q    <= feed_reset_d;
      busy_q          <= busy_d;
      samples_sent_q  <= samples_sent_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign clk_sample    = clk_sample_q;
  assign sample_valid  = sample_valid_q;
  assign data          = data_q;
  assign feed_reset    = feed_reset_q;
  assign feed_complete = feed_complete_q;
  assign busy          = busy_q;
  assign samples_sent  = samples_sent_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: a wide-address instance and a 2-bit-address instance share one memory model.
// Expected sample streams come from plain memory indexing, checked against a cycle monitor.
module tb_sample_feeder;

  localparam int IW  = 3;
  localparam int AW  = 14;
  localparam int AWB = 2;
  localparam int DIV = 4;
  localparam int RC  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_req, pause, sel;
  logic [AW:0]   num_samples;
  logic          start_a, start_b;
  assign start_a = start_req & ~sel;
  assign start_b = start_req & sel;

  logic [AW-1:0]  addr_a;
  logic [AWB-1:0] addr_b;
  logic [IW-1:0]  mdata_a, mdata_b, data_a, data_b;
  logic           cs_a, cs_b, sv_a, sv_b, fr_a, fr_b, fc_a, fc_b, busy_a, busy_b;
  logic [AW:0]    ss_a;
  logic [AWB:0]   ss_b;

  logic [IW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    mdata_a <= mem[addr_a];
    mdata_b <= mem[{{(AW-AWB){1'b0}}, addr_b}];
  end

  sample_feeder #(.INPUT_WIDTH(IW), .ADDR_WIDTH(AW), .DIV(DIV), .RESET_CYCLES(RC)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .num_samples(num_samples), .pause(pause),
    .mem_addr(addr_a), .mem_data(mdata_a), .clk_sample(cs_a), .sample_valid(sv_a),
    .data(data_a), .feed_reset(fr_a), .feed_complete(fc_a), .busy(busy_a), .samples_sent(ss_a));

  sample_feeder #(.INPUT_WIDTH(IW), .ADDR_WIDTH(AWB), .DIV(DIV), .RESET_CYCLES(RC)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .num_samples(num_samples[AWB:0]), .pause(pause),
    .mem_addr(addr_b), .mem_data(mdata_b), .clk_sample(cs_b), .sample_valid(sv_b),
    .data(data_b), .feed_reset(fr_b), .feed_complete(fc_b), .busy(busy_b), .samples_sent(ss_b));

  logic          m_clk, m_fr, m_fc, m_busy;
  logic [IW-1:0] m_data;
  logic [AW:0]   m_ss;
  assign m_clk  = sel ? cs_b   : cs_a;
  assign m_fr   = sel ? fr_b   : fr_a;
  assign m_fc   = sel ? fc_b   : fc_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_data = sel ? data_b : data_a;
  assign m_ss   = sel ? {{(AW-AWB){1'b0}}, ss_b} : ss_a;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor state
  logic [IW-1:0] obs[$];
  int            rise_cyc[$];
  int            cyc, fr_cycles, since_change;
  logic          prev_clk, prev_fr, fr_fall_fc;
  logic [IW-1:0] prev_data;

  task automatic mon_init();
    obs.delete();
    rise_cyc.delete();
    cyc = 0; fr_cycles = 0; since_change = 0; fr_fall_fc = 1'b0;
    prev_clk = m_clk; prev_fr = m_fr; prev_data = m_data;
  endtask

  task automatic observe();
    cyc++;
    if (m_data !== prev_data) since_change = 0;
    else since_change++;
    if (m_clk && !prev_clk) begin
      obs.push_back(m_data);
      rise_cyc.push_back(cyc);
      check("data_setup", (since_change >= DIV / 2) ? 32'd1 : 32'd0, 32'd1);
    end
    if (m_fr) fr_cycles++;
    if (prev_fr && !m_fr) fr_fall_fc = m_fc;
    prev_clk = m_clk; prev_fr = m_fr; prev_data = m_data;
  endtask

  task automatic run_feed(input int n, input int p_after, input int p_len, input int mid,
                          input bit use_b, input int exp_sent, input string tag);
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] held;
    int t, budget;
    bit done, paused_done;
    sel = use_b;
    num_samples = (AW + 1)'(n);
    for (int k = 0; k < n; k++) exp_q.push_back(mem[use_b ? (k % (1 << AWB)) : (k % (1 << AW))]);
    step();
    mon_init();
    start_req = 1'b1;
    step(); observe();
    start_req = 1'b0;
    check({tag, "_fc_clear"}, m_fc, 1'b0);
    check({tag, "_busy_start"}, m_busy, 1'b1);
    t = 0; done = 0; paused_done = 0;
    budget = RC + 20 + n * DIV + p_len;
    while (!done && t < budget) begin
      if (p_len > 0 && !paused_done && obs.size() == p_after) begin
        held = m_data;
        pause = 1'b1;
        for (int i = 1; i <= p_len; i++) begin
          step(); observe(); t++;
          if (i >= 2) check({tag, "_pause_clk"}, m_clk, 1'b0);
          check({tag, "_pause_data"}, m_data, held);
        end
        pause = 1'b0;
        paused_done = 1;
      end else begin
        if (t == mid) begin
          check({tag, "_busy_at_midstart"}, m_busy, 1'b1);
          start_req = 1'b1;
        end
        step(); observe();
        start_req = 1'b0;
        t++;
        if (m_fc) done = 1;
      end
    end
    check({tag, "_timeout"}, done, 1'b1);
    check({tag, "_rises"}, obs.size(), exp_sent);
    for (int k = 0; k < n && k < obs.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), obs[k], exp_q[k]);
      if (k > 0 && p_len == 0) check($sformatf("%s_gap%0d", tag, k), rise_cyc[k] - rise_cyc[k-1], DIV);
    end
    check({tag, "_fr_len"}, fr_cycles, RC);
    check({tag, "_fc_at_fr_fall"}, fr_fall_fc, (n == 0) ? 1'b1 : 1'b0);
    check({tag, "_busy_end"}, m_busy, 1'b0);
    check({tag, "_sent"}, m_ss, exp_sent);
    for (int i = 0; i < 3; i++) begin step(); observe(); end
    check({tag, "_fc_hold"}, m_fc, 1'b1);
    check({tag, "_no_extra"}, obs.size(), exp_sent);
  endtask

  typedef struct {
    int n; int p_after; int p_len; int mid; bit use_b; int exp_sent;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n, pa, pl, md;
    bit ub;
    reset = 1'b1; start_req = 1'b0; pause = 1'b0; sel = 1'b0; num_samples = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom_range(0, 7));
    mem[0] = 3'd5; mem[1] = 3'd2; mem[2] = 3'd7;

    vecs[0] = '{3, 0, 0, -1, 1'b0, 3};   // basic three-sample feed
    vecs[1] = '{0, 0, 0, -1, 1'b0, 0};   // empty feed
    vecs[2] = '{3, 1, 10, -1, 1'b0, 3};  // pause after first sample
    vecs[3] = '{4, 0, 0, 12, 1'b0, 4};   // start pulsed mid-feed
    vecs[4] = '{6, 0, 0, -1, 1'b1, 6};   // address wrap on 2-bit instance
    vecs[5] = '{1, 0, 0, -1, 1'b0, 1};

    repeat (3) step();
    check("rst_clk_sample", cs_a, 1'b0);
    check("rst_valid", sv_a, 1'b0);
    check("rst_data", data_a, 3'd0);
    check("rst_feed_reset", fr_a, 1'b0);
    check("rst_fc", fc_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_addr", addr_a, 14'd0);
    check("rst_sent", ss_a, 15'd0);
    check("rst_b_busy", busy_b, 1'b0);
    check("rst_b_addr", addr_b, 2'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++)
      run_feed(vecs[i].n, vecs[i].p_after, vecs[i].p_len, vecs[i].mid, vecs[i].use_b,
               vecs[i].exp_sent, $sformatf("v%0d", i));

    // Reset during the second sample-clock high aborts the feed.
    sel = 1'b0;
    num_samples = (AW + 1)'(3);
    step();
    mon_init();
    start_req = 1'b1; step(); observe(); start_req = 1'b0;
    for (int i = 0; i < 60 && obs.size() < 2; i++) begin step(); observe(); end
    check("abort_reached_2nd", obs.size(), 2);
    check("abort_clk_high", cs_a, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_clk_sample", cs_a, 1'b0);
    check("abort_valid", sv_a, 1'b0);
    check("abort_data", data_a, 3'd0);
    check("abort_feed_reset", fr_a, 1'b0);
    check("abort_fc", fc_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_addr", addr_a, 14'd0);
    check("abort_sent", ss_a, 15'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_stays_idle", {fc_a, busy_a, cs_a}, 3'b000);
    end
    run_feed(3, 0, 0, -1, 1'b0, 3, "replay");

    // Randomized feeds against the memory-indexing model.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = IW'($urandom_range(0, 7));
      ub = 1'($urandom_range(0, 1));
      n  = ub ? $urandom_range(0, 7) : $urandom_range(0, 12);
      pa = 0; pl = 0; md = -1;
      if (n >= 2 && $urandom_range(0, 1) == 1) begin
        pa = $urandom_range(1, n - 1);
        pl = $urandom_range(1, 8);
      end
      if (n >= 1 && $urandom_range(0, 1) == 1) md = $urandom_range(1, 2 + n * DIV);
      run_feed(n, pa, pl, md, ub, n, $sformatf("r%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
